// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-2 Booth multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } booth_state_e;

  localparam int WIDTH_MIN = 4;
  localparam int WIDTH_MAX = 32;

  function automatic bit width_ok(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

  // Bit prepended to an operand: its MSB in signed mode, 0 in unsigned mode.
  function automatic logic ext_bit(input logic msb, input logic is_signed);
    return is_signed & msb;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth step: conditional add/subtract of M into A, then an
// arithmetic right shift of {A,Q,Q_1} by one bit.
module booth_step #(
  parameter int OW = 9
) (
  input  logic [OW:0]   a,
  input  logic [OW-1:0] q,
  input  logic          q_1,
  input  logic [OW-1:0] m,
  output logic [OW:0]   a_nx,
  output logic [OW-1:0] q_nx,
  output logic          q_1_nx
);

  logic [OW:0] m_wide;
  logic [OW:0] sum;

  assign m_wide = {m[OW-1], m};

  always_comb begin
    sum = a;
    case ({q[0], q_1})
      2'b01:   sum = a + m_wide;
      2'b10:   sum = a - m_wide;
      default: sum = a;
    endcase
  end

  // Duplicating sum's MSB keeps the shift arithmetic; Q's LSB falls into Q_1.
  assign {a_nx, q_nx, q_1_nx} = {sum[OW], sum, q};

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with per-transaction signed/unsigned mode.
// Optional BOOTH_ZERO_SKIP_EN: zero operands go straight to DONE with product 0.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic [1:0]         dbg_state
);

  localparam int OW = WIDTH + 1;
  localparam int CW = $clog2(OW + 1);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_RUN  = ST_RUN;
  localparam logic [1:0] S_DONE = ST_DONE;

  if (!width_ok(WIDTH)) begin : g_width_check
    $error("booth_mult_seq: WIDTH must be within 4..32");
  end

  // Handshakes: a transfer happens on any clk edge where valid && ready.
  // in_ready is high only in IDLE; out_valid/product hold in DONE until out_ready.
  logic [1:0]    state;
  logic [OW:0]   a;
  logic [OW-1:0] q;
  logic          q_1;
  logic [OW-1:0] m;
  logic [CW-1:0] cnt;

  logic [OW-1:0] m_ext;
  logic [OW-1:0] q_ext;
  logic [OW:0]   a_nx;
  logic [OW-1:0] q_nx;
  logic          q_1_nx;

  assign m_ext     = {ext_bit(multiplicand[WIDTH-1], is_signed), multiplicand};
  assign q_ext     = {ext_bit(multiplier[WIDTH-1], is_signed), multiplier};
  assign in_ready  = (state == S_IDLE);
  assign dbg_state = state;

  booth_step #(.OW(OW)) u_step (
    .a      (a),
    .q      (q),
    .q_1    (q_1),
    .m      (m),
    .a_nx   (a_nx),
    .q_nx   (q_nx),
    .q_1_nx (q_1_nx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      product   <= '0;
      a         <= '0;
      q         <= '0;
      q_1       <= 1'b0;
      m         <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a   <= '0;
            q   <= q_ext;
            q_1 <= 1'b0;
            m   <= m_ext;
            cnt <= CW'(OW);
`ifdef BOOTH_ZERO_SKIP_EN
            if ((multiplicand == '0) || (multiplier == '0)) begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              product   <= '0;
            end else begin
              state <= S_RUN;
            end
`else
            state <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          a   <= a_nx;
          q   <= q_nx;
          q_1 <= q_1_nx;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            // Low 2*WIDTH bits of the post-shift {A,Q}.
            product   <= {a_nx[WIDTH-2:0], q_nx};
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq (WIDTH=8); honours BOOTH_ZERO_SKIP_EN.
`timescale 1ns/1ps
module tb_booth_mult_seq;

  localparam int W = 8;
  localparam int OW = W + 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   multiplicand = '0;
  logic [W-1:0]   multiplier = '0;
  logic           is_signed = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] product;
  logic [1:0]     dbg_state;

  int checks = 0;
  int failures = 0;

  logic [2*W-1:0] exp_q[$];
  int             lat_q[$];
  longint         tacc_q[$];

  logic           hold_mode = 1'b0;
  logic           hold_val = 1'b0;

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .is_signed    (is_signed),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .dbg_state    (dbg_state)
  );

  // Clock: posedges at 5,15,25...; negedges sample outputs.
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] mv, input logic [W-1:0] qv,
                                               input logic s);
    int   a_i;
    int   b_i;
    int   p;
    a_i = s ? int'($signed(mv)) : int'(mv);
    b_i = s ? int'($signed(qv)) : int'(qv);
    p = a_i * b_i;
    return p[2*W-1:0];
  endfunction

  // Edges between the accept edge and the edge that raises out_valid.
  function automatic int ref_lat(input logic [W-1:0] mv, input logic [W-1:0] qv);
`ifdef BOOTH_ZERO_SKIP_EN
    if (mv == '0 || qv == '0) return 0;
`endif
    return OW;
  endfunction

  task automatic send(input logic [W-1:0] mv, input logic [W-1:0] qv, input logic s);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 64'(in_ready), 64'd1);
      return;
    end
    in_valid     = 1'b1;
    multiplicand = mv;
    multiplier   = qv;
    is_signed    = s;
    @(posedge clk);
    exp_q.push_back(ref_prod(mv, qv, s));
    lat_q.push_back(ref_lat(mv, qv));
    tacc_q.push_back(longint'($time));
    #1;
    in_valid     = 1'b0;
    multiplicand = W'($urandom);
    multiplier   = W'($urandom);
    is_signed    = 1'($urandom);
  endtask

  // out_ready changes just after each posedge so it is stable at the negedge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = hold_mode ? hold_val : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops the scoreboard when a product first appears, then watches
  // that it holds until the handshake and that IDLE follows it.
  logic           in_hold = 1'b0;
  logic           after_hs = 1'b0;
  logic [2*W-1:0] held;
  always @(negedge clk) begin
    if (!rst_n) begin
      in_hold  = 1'b0;
      after_hs = 1'b0;
    end else begin
      if (after_hs) begin
        chk("post_hs_out_valid", 64'(out_valid), 64'd0);
        chk("post_hs_in_ready", 64'(in_ready), 64'd1);
        after_hs = 1'b0;
      end
      if (out_valid && !in_hold) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 64'(out_valid), 64'd0);
        end else begin
          logic [2*W-1:0] e;
          int             el;
          longint         ta;
          e  = exp_q.pop_front();
          el = lat_q.pop_front();
          ta = tacc_q.pop_front();
          chk("product", 64'(product), 64'(e));
          chk("latency", 64'((longint'($time) - ta - 5) / 10), 64'(el));
        end
        chk("done_in_ready", 64'(in_ready), 64'd0);
        held    = product;
        in_hold = 1'b1;
      end else if (out_valid && in_hold) begin
        chk("hold_product", 64'(product), 64'(held));
        chk("hold_in_ready", 64'(in_ready), 64'd0);
      end
      if (out_valid && out_ready) begin
        after_hs = 1'b1;
        in_hold  = 1'b0;
      end
    end
  end

  initial begin
    int n;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_product", 64'(product), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    send(8'h80, 8'h80, 1'b1);
    send(8'hFF, 8'hFF, 1'b0);
    send(8'hFF, 8'hFF, 1'b1);
    send(8'h7F, 8'h80, 1'b1);
    send(8'd200, 8'd3, 1'b0);
    send(8'h00, 8'd77, 1'b1);
    send(8'd77, 8'h00, 1'b0);
    for (int i = 0; i < 30; i++)
      send(W'($urandom), W'($urandom), 1'($urandom));

    // Hold the result for 5 cycles, then accept it with a 1-cycle out_ready.
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    hold_mode = 1'b1;
    hold_val  = 1'b0;
    repeat (3) @(negedge clk);
    send(8'hC3, 8'h5A, 1'b1);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("hold_wait_out_valid", 64'(out_valid), 64'd1);
    repeat (5) @(negedge clk);
    chk("hold_still_valid", 64'(out_valid), 64'd1);
    hold_val = 1'b1;
    @(negedge clk);
    hold_val = 1'b0;
    @(negedge clk);
    chk("hold_released_in_ready", 64'(in_ready), 64'd1);

    // Reset in the middle of RUN abandons the operation.
    send(8'd9, 8'd7, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    lat_q.delete();
    tacc_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrun_rst_out_valid", 64'(out_valid), 64'd0);
    chk("midrun_rst_product", 64'(product), 64'd0);
    chk("midrun_rst_in_ready", 64'(in_ready), 64'd1);
    hold_mode = 1'b0;
    send(8'd5, 8'd6, 1'b0);
    send(8'd5, 8'd6, 1'b1);

    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_out_valid", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
